noc_local_ni: RTL and testbench

- Node-side network interface at the LOCAL port of one 2x4 mesh router.
- Inject path: packs host requests into 32-bit flits and drives the router's local input (data, valid), honouring the router's local FIFO full flag.
- Eject path: sinks the router's local output. That output has no backpressure, so flits are buffered in a small FIFO and presented to the host via valid/ready; overflow flits are dropped and counted.

---
 rtl/noc_ni_pkg.sv | 26 ++
 rtl/noc_local_ni_eject_fifo.sv | 82 ++++++++
 rtl/noc_local_ni.sv | 115 +++++++++++
 tb/tb_noc_local_ni.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_ni_pkg.sv
// Shared definitions for the LOCAL-port network interface: flit geometry,
// field positions and the saturating counter helper.
package noc_ni_pkg;

  localparam int ADDR_W    = 3;
  localparam int FLIT_W    = 32;
  localparam int PAYLOAD_W = 26;

  // Flit layout, identical for inject and eject: {payload, src, dst}
  localparam int DST_LSB = 0;
  localparam int DST_MSB = 2;
  localparam int SRC_LSB = 3;
  localparam int SRC_MSB = 5;
  localparam int PL_LSB  = 6;
  localparam int PL_MSB  = 31;

  localparam int DROP_W  = 8;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    return ({1'b0, v} >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/noc_local_ni_eject_fifo.sv
// Eject buffer for the router's LOCAL output. The router cannot be stalled,
// so a flit arriving with no room is dropped and counted; the host side is a
// first-word-fall-through valid/ready interface.
module ni_eject_fifo
  import noc_ni_pkg::*;
#(
  parameter int EJ_DEPTH = 4,
  parameter int DATA_W   = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_req,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic [DATA_W-1:0] o_head,
  output logic [DROP_W-1:0] o_drop_count,
  output logic              o_overflow
);

  localparam int PTR_W = $clog2(EJ_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [EJ_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [DROP_W-1:0] r_drop_count;
  logic              r_overflow;

  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;
  logic [OCC_W-1:0]  w_count_nxt;

  assign o_rx_valid = (r_count != '0);
  assign w_pop      = o_rx_valid & i_rx_ready;
  assign w_full     = (r_count == OCC_W'(EJ_DEPTH));
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign w_wr       = i_wr_req & (~w_full | w_pop);
  assign w_drop     = i_wr_req & ~w_wr;

  assign o_head       = o_rx_valid ? r_mem[r_rd_ptr] : '0;
  assign o_drop_count = r_drop_count;
  assign o_overflow   = r_overflow;

  // Next occupancy: write and pop together leave it unchanged.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_count_nxt = r_count;
    if (w_wr && !w_pop)      w_count_nxt = r_count + OCC_W'(1);
    else if (!w_wr && w_pop) w_count_nxt = r_count - OCC_W'(1);
  end

  // Pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop) begin
        r_drop_count <= DROP_W'(sat_inc(32'(r_drop_count), DROP_W));
        r_overflow   <= 1'b1;
      end
    end
  end

  // Flit storage.
  // NOTE: the storage array is not reset; occupancy gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/noc_local_ni.sv
// Network interface at the LOCAL port of a mesh router: packs host requests
// into flits for the router and buffers ejected flits for the host.
// Optional build macro NOC_NI_DST_CHECK_EN adds a destination check on
// ejected flits with a misroute_count output.
module noc_local_ni
  import noc_ni_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NODE_ADDR = 3'b001,
  parameter int                EJ_DEPTH  = 4,
  parameter int                CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [ADDR_W-1:0]    tx_dst,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic [FLIT_W-1:0]    noc_data_out,
  output logic                 noc_valid_out,
  input  logic                 noc_full_in,
  input  logic [FLIT_W-1:0]    noc_data_in,
  input  logic                 noc_valid_in,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [ADDR_W-1:0]    rx_src,
  output logic [PAYLOAD_W-1:0] rx_payload,
  output logic [CNT_W-1:0]     tx_count,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 overflow
`ifdef NOC_NI_DST_CHECK_EN
  ,
  output logic [DROP_W-1:0]    misroute_count
`endif
);

  // The eject FIFO stores only src and payload; dst is consumed on arrival.
  localparam int HEAD_W = FLIT_W - SRC_LSB;

  logic [FLIT_W-1:0] r_tx_buf;
  logic              r_tx_buf_v;
  logic [CNT_W-1:0]  r_tx_count;

  logic              w_send;
  logic              w_hs;
  logic              w_ej_req;
  logic [HEAD_W-1:0] w_head;

  // The router silently drops writes into its full FIFO, so never drive valid while full.
  assign w_send        = r_tx_buf_v & ~noc_full_in;
  assign noc_valid_out = w_send;
  assign noc_data_out  = w_send ? r_tx_buf : '0;
  assign tx_ready      = ~r_tx_buf_v | ~noc_full_in;
  assign w_hs          = tx_valid & tx_ready;
  assign tx_count      = r_tx_count;

  // Inject holding register: reload on handshake (also when sending), clear on a lone send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf   <= '0;
      r_tx_buf_v <= 1'b0;
      r_tx_count <= '0;
    end else begin
      if (w_hs) begin
        r_tx_buf   <= {tx_payload, NODE_ADDR, tx_dst};
        r_tx_buf_v <= 1'b1;
      end else if (w_send) begin
        r_tx_buf_v <= 1'b0;
      end
      if (w_send) r_tx_count <= CNT_W'(sat_inc(32'(r_tx_count), CNT_W));
    end
  end

`ifdef NOC_NI_DST_CHECK_EN
  logic              w_dst_ok;
  logic [DROP_W-1:0] r_misroute_count;

  // Destination check takes priority over the FIFO full check.
  assign w_dst_ok       = (noc_data_in[DST_MSB:DST_LSB] == NODE_ADDR);
  assign w_ej_req       = noc_valid_in & w_dst_ok;
  assign misroute_count = r_misroute_count;

  // Count flits addressed to another node.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misroute_count <= '0;
    end else if (noc_valid_in && !w_dst_ok) begin
      r_misroute_count <= DROP_W'(sat_inc(32'(r_misroute_count), DROP_W));
    end
  end
`else
  logic w_unused_dst;

  assign w_ej_req     = noc_valid_in;
  assign w_unused_dst = ^noc_data_in[DST_MSB:DST_LSB];
`endif

  ni_eject_fifo #(
    .EJ_DEPTH (EJ_DEPTH),
    .DATA_W   (HEAD_W)
  ) u_eject_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_req     (w_ej_req),
    .i_wr_data    (noc_data_in[FLIT_W-1:SRC_LSB]),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (rx_ready),
    .o_head       (w_head),
    .o_drop_count (drop_count),
    .o_overflow   (overflow)
  );

  assign rx_src     = w_head[SRC_MSB-SRC_LSB:0];
  assign rx_payload = w_head[PL_MSB-SRC_LSB:PL_LSB-SRC_LSB];

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_noc_local_ni;

  localparam logic [2:0] NODE  = 3'b001;
  localparam int         DEPTH = 4;
  localparam int         CW    = 16;
  localparam int         CMAX  = (1 << CW) - 1;

  logic        clk;
  logic        rst_n;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  tx_dst;
  logic [25:0] tx_payload;
  logic [31:0] noc_data_out;
  logic        noc_valid_out;
  logic        noc_full_in;
  logic [31:0] noc_data_in;
  logic        noc_valid_in;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  rx_src;
  logic [25:0] rx_payload;
  logic [CW-1:0] tx_count;
  logic [7:0]  drop_count;
  logic        overflow;
`ifdef NOC_NI_DST_CHECK_EN
  logic [7:0]  misroute_count;
`endif

  noc_local_ni #(
    .NODE_ADDR (NODE),
    .EJ_DEPTH  (DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_dst         (tx_dst),
    .tx_payload     (tx_payload),
    .noc_data_out   (noc_data_out),
    .noc_valid_out  (noc_valid_out),
    .noc_full_in    (noc_full_in),
    .noc_data_in    (noc_data_in),
    .noc_valid_in   (noc_valid_in),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_src         (rx_src),
    .rx_payload     (rx_payload),
    .tx_count       (tx_count),
    .drop_count     (drop_count),
    .overflow       (overflow)
`ifdef NOC_NI_DST_CHECK_EN
    ,
    .misroute_count (misroute_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_txq[$];   // flits accepted from the host, not yet sent
  logic [31:0] m_rxq[$];   // flits waiting for the host
  int          m_tx_count;
  int          m_drop;
  int          m_misroute;
  logic        m_ovf;

  logic [31:0] e_data;
  logic [31:0] e_head;
  logic        e_valid;
  logic        e_ready;
  logic        e_send;
  logic        e_hs;
  logic        e_pop;
  logic        e_room;
  logic        e_dst_ok;

  task automatic model_clear();
    m_txq.delete();
    m_rxq.delete();
    m_tx_count = 0;
    m_drop     = 0;
    m_misroute = 0;
    m_ovf      = 1'b0;
  endtask

  // Compare process: checks every cycle mid-low-phase, then advances the model
  // by what the coming rising edge must do.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      #2;
      e_valid = (m_txq.size() != 0) && !noc_full_in;
      e_ready = (m_txq.size() == 0) || !noc_full_in;
      e_data  = e_valid ? m_txq[0] : 32'd0;
      e_head  = (m_rxq.size() != 0) ? m_rxq[0] : 32'd0;
      if (!rst_n) begin
        model_clear();
        check("rst_noc_valid", 32'(noc_valid_out), 32'd0);
        check("rst_noc_data", noc_data_out, 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
      end else begin
        check("tx_ready", 32'(tx_ready), 32'(e_ready));
        check("noc_valid_out", 32'(noc_valid_out), 32'(e_valid));
        check("noc_data_out", noc_data_out, e_data);
        check("rx_valid", 32'(rx_valid), 32'(m_rxq.size() != 0));
        check("rx_src", 32'(rx_src), 32'(e_head[5:3]));
        check("rx_payload", 32'(rx_payload), 32'(e_head[31:6]));
        check("tx_count", 32'(tx_count), 32'(m_tx_count));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef NOC_NI_DST_CHECK_EN
        check("misroute_count", 32'(misroute_count), 32'(m_misroute));
`endif
        // inject side
        e_send = e_valid;
        e_hs   = tx_valid && e_ready;
        if (e_send) begin
          void'(m_txq.pop_front());
          if (m_tx_count < CMAX) m_tx_count++;
        end
        if (e_hs) m_txq.push_back({tx_payload, NODE, tx_dst});
        // eject side
        e_pop    = (m_rxq.size() != 0) && rx_ready;
        e_room   = (m_rxq.size() < DEPTH) || e_pop;
        e_dst_ok = 1'b1;
`ifdef NOC_NI_DST_CHECK_EN
        e_dst_ok = (noc_data_in[2:0] == NODE);
`endif
        if (e_pop) void'(m_rxq.pop_front());
        if (noc_valid_in) begin
          if (!e_dst_ok) begin
            if (m_misroute < 255) m_misroute++;
          end else if (e_room) begin
            m_rxq.push_back(noc_data_in);
          end else begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    tx_valid     = 1'b0;
    tx_dst       = 3'd0;
    tx_payload   = 26'd0;
    noc_full_in  = 1'b0;
    noc_data_in  = 32'd0;
    noc_valid_in = 1'b0;
    rx_ready     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int cnt;
  int bias;

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // T1: single flit, one cycle after the handshake, exactly one pulse.
    // {26'h155AAAA, 3'd1, 3'd6} = 0x556AAA80 | 0x8 | 0x6
    tx_valid = 1'b1; tx_dst = 3'd6; tx_payload = 26'h155_AAAA;
    step(); tx_valid = 1'b0; #1;
    check("t1_valid", 32'(noc_valid_out), 32'd1);
    check("t1_flit", noc_data_out, 32'h556A_AA8E);
    step(); #1;
    check("t1_single_pulse", 32'(noc_valid_out), 32'd0);
    check("t1_tx_count", 32'(tx_count), 32'd1);
    // Same with payload bit 25 set: flit bit 31 set.
    step(); tx_valid = 1'b1; tx_dst = 3'd6; tx_payload = 26'h355_AAAA;
    step(); tx_valid = 1'b0; #1;
    check("t1b_flit", noc_data_out, 32'hD56A_AA8E);
    step();

    // T2: five back-to-back flits.
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      tx_valid   = (i < 5);
      tx_dst     = 3'(i);
      tx_payload = 26'(100 + i);
      #1;
      if (noc_valid_out) cnt++;
    end
    check("t2_valid_cycles", 32'(cnt), 32'd5);
    check("t2_tx_count", 32'(tx_count), 32'd7);

    // T3: router full for three cycles with a flit held.
    step(); tx_valid = 1'b1; tx_dst = 3'd2; tx_payload = 26'd200;
    for (int i = 0; i < 3; i++) begin
      step(); noc_full_in = 1'b1; tx_valid = 1'b1; tx_payload = 26'd201; #1;
      check("t3_stall_valid", 32'(noc_valid_out), 32'd0);
      check("t3_stall_ready", 32'(tx_ready), 32'd0);
    end
    step(); noc_full_in = 1'b0; tx_valid = 1'b0; #1;
    check("t3_release_valid", 32'(noc_valid_out), 32'd1);
    check("t3_release_payload", 32'(noc_data_out[31:6]), 32'd200);
    step(); #1;
    check("t3_no_duplicate", 32'(noc_valid_out), 32'd0);
    check("t3_tx_count", 32'(tx_count), 32'd8);

    // T4: six flits into a 4-deep FIFO with the host stalled.
    for (int k = 0; k < 6; k++) begin
      step(); noc_valid_in = 1'b1; noc_data_in = {26'(k + 1), 3'd4, NODE};
    end
    step(); noc_valid_in = 1'b0; rx_ready = 1'b1; #1;
    check("t4_drop_count", 32'(drop_count), 32'd2);
    check("t4_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t4_order", 32'(rx_payload), 32'(i + 1));
      step(); #1;
    end
    check("t4_drained", 32'(rx_valid), 32'd0);

    // T5: full FIFO with pop and write together keeps everything.
    rx_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); noc_valid_in = 1'b1; noc_data_in = {26'(10 + k), 3'd3, NODE};
    end
    step(); noc_valid_in = 1'b1; noc_data_in = {26'd20, 3'd3, NODE}; rx_ready = 1'b1;
    step(); noc_valid_in = 1'b0; rx_ready = 1'b0; #1;
    check("t5_drop_unchanged", 32'(drop_count), 32'd2);
    check("t5_head", 32'(rx_payload), 32'd11);
    rx_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rx_valid) cnt++;
      step(); #1;
    end
    check("t5_occupancy", 32'(cnt), 32'd4);
    rx_ready = 1'b0;

`ifdef NOC_NI_DST_CHECK_EN
    // T6: flit for node 5 arriving at node 1.
    step(); noc_valid_in = 1'b1; noc_data_in = {26'd3, 3'd2, 3'd5};
    step(); noc_valid_in = 1'b0; #1;
    check("t6_misroute", 32'(misroute_count), 32'd1);
    check("t6_no_rx", 32'(rx_valid), 32'd0);
    check("t6_drop_same", 32'(drop_count), 32'd2);
`endif

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      step(); noc_valid_in = 1'b1; noc_data_in = {26'(i), 3'd5, NODE};
    end
    step(); noc_valid_in = 1'b0; #1;
    check("sat_drop", 32'(drop_count), 32'd255);
    rx_ready = 1'b1;
    repeat (6) step();
    idle();

    // Mid-operation reset while a flit is being driven.
    step(); tx_valid = 1'b1; tx_dst = 3'd7; tx_payload = 26'h2AA;
    step(); tx_valid = 1'b0; noc_full_in = 1'b1;
    step(); noc_full_in = 1'b0; #1;
    check("mid_pre_valid", 32'(noc_valid_out), 32'd1);
    rst_n = 1'b0; #1;
    check("mid_async_valid", 32'(noc_valid_out), 32'd0);
    check("mid_async_data", noc_data_out, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Randomized traffic, alternating eject drain rate.
    bias = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) bias = $urandom_range(0, 3);
      step();
      tx_valid     = ($urandom_range(0, 3) != 0);
      tx_dst       = 3'($urandom_range(0, 7));
      tx_payload   = 26'($urandom);
      noc_full_in  = ($urandom_range(0, 3) == 0);
      noc_valid_in = ($urandom_range(0, 1) == 1);
      noc_data_in  = {26'($urandom), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : NODE};
      rx_ready     = ($urandom_range(0, 3) < bias);
    end
    idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
